// File: rtl/bcd_fib_param_pkg.sv
// Shared types and constant helpers for the BCD Fibonacci calculator.
// Widths are derived at elaboration time from the digit counts.
package bcd_fib_param_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_FIB,
      ST_CONV,
      ST_DONE
   } state_e;

   function automatic int pow10(input int d);
      int r;
      r = 1;
      for (int i = 0; i < d; i++) r = r * 10;
      return r;
   endfunction

   // Ceiling log2; clog2(1) = 0.
   function automatic int clog2(input int v);
      int    r;
      longint p;
      r = 0;
      p = 1;
      while (p < longint'(v)) begin
         p = p * 2;
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/bin2bcd_dd.sv
// Load/shift double-dabble converter: BIN_W steps after load, one bit per clock.
// done_tick_o marks the cycle of the final step; bcd_o is valid from the next cycle.
module bin2bcd_dd #(
   parameter int BIN_W      = 15,
   parameter int OUT_DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    load_i,
   input  logic [BIN_W-1:0]        bin_i,
   output logic [4*OUT_DIGITS-1:0] bcd_o,
   output logic                    done_tick_o
);
   import bcd_fib_param_pkg::*;

   localparam int CNT_W = clog2(BIN_W + 1);

   logic [BIN_W-1:0]        bin_q, bin_d;
   logic [4*OUT_DIGITS-1:0] bcd_q, bcd_d, bcd_adj;
   logic [CNT_W-1:0]        cnt_q, cnt_d;

   always_comb begin
      bcd_adj = bcd_q;
      for (int d = 0; d < OUT_DIGITS; d++) begin
         if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
      end
      bin_d = bin_q;
      bcd_d = bcd_q;
      cnt_d = cnt_q;
      if (load_i) begin
         bin_d = bin_i;
         bcd_d = '0;
         cnt_d = CNT_W'(BIN_W);
      end else if (cnt_q != '0) begin
         bcd_d = {bcd_adj[4*OUT_DIGITS-2:0], bin_q[BIN_W-1]};
         bin_d = {bin_q[BIN_W-2:0], 1'b0};
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         bin_q <= '0;
         bcd_q <= '0;
         cnt_q <= '0;
      end else begin
         bin_q <= bin_d;
         bcd_q <= bcd_d;
         cnt_q <= cnt_d;
      end
   end

   assign bcd_o       = bcd_q;
   assign done_tick_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/bcd_fib_param.sv
// BCD-in / BCD-out Fibonacci calculator with saturating overflow and bad-digit flag.
//   state | meaning
//   IDLE  | waiting for start, ready=1
//   LOAD  | fold BCD index into binary, most significant digit first
//   FIB   | iterate t0,t1 until n exhausted or t0 exceeds the output range
//   CONV  | double-dabble of sat(t0) in the sub-module
//   DONE  | latch results; done_tick follows on the next cycle
module bcd_fib_param
   import bcd_fib_param_pkg::*;
#(
   parameter int IN_DIGITS  = 2,
   parameter int OUT_DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic [4*IN_DIGITS-1:0]  bcd_in,
   output logic                    ready,
   output logic                    done_tick,
   output logic [4*OUT_DIGITS-1:0] bcd_out,
   output logic                    ovf,
   output logic                    err
);

   localparam int IDX_W = clog2(pow10(IN_DIGITS));
   localparam int BIN_W = clog2(3 * pow10(OUT_DIGITS));
   localparam logic [BIN_W-1:0] MAX_V = BIN_W'(pow10(OUT_DIGITS) - 1);

   state_e                  state_q, state_d;
   logic [4*IN_DIGITS-1:0]  din_q, din_d;
   logic [IDX_W-1:0]        idx_q, idx_d, idx_next, n_q, n_d;
   logic [1:0]              dcnt_q, dcnt_d;
   logic [BIN_W-1:0]        t0_q, t0_d, t1_q, t1_d;
   logic                    ovf_p_q, ovf_p_d, err_p_q, err_p_d;
   logic                    ready_q, ready_d, done_q, done_d;
   logic [4*OUT_DIGITS-1:0] bcd_out_q, bcd_out_d;
   logic                    ovf_q, ovf_d, err_q, err_d;
   logic [3:0]              digit;
   logic                    bad;
   logic                    t0_big;
   logic                    dd_load, dd_done;
   logic [BIN_W-1:0]        dd_bin;
   logic [4*OUT_DIGITS-1:0] dd_bcd;

   assign t0_big = (t0_q > MAX_V);
   assign dd_bin = t0_big ? MAX_V : t0_q;

   always_comb begin
      state_d   = state_q;
      din_d     = din_q;
      idx_d     = idx_q;
      n_d       = n_q;
      dcnt_d    = dcnt_q;
      t0_d      = t0_q;
      t1_d      = t1_q;
      ovf_p_d   = ovf_p_q;
      err_p_d   = err_p_q;
      bcd_out_d = bcd_out_q;
      ovf_d     = ovf_q;
      err_d     = err_q;
      dd_load   = 1'b0;
      bad       = 1'b0;
      digit     = '0;
      for (int i = 0; i < IN_DIGITS; i++) begin
         if (dcnt_q == 2'(i)) digit = din_q[4*i +: 4];
      end
      idx_next = (idx_q << 3) + (idx_q << 1) + IDX_W'(digit);

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               din_d = bcd_in;
               for (int i = 0; i < IN_DIGITS; i++) begin
                  if (bcd_in[4*i +: 4] > 4'd9) bad = 1'b1;
               end
               if (bad) begin
                  err_p_d = 1'b1;
                  ovf_p_d = 1'b0;
                  state_d = ST_DONE;
               end else begin
                  err_p_d = 1'b0;
                  idx_d   = '0;
                  dcnt_d  = 2'(IN_DIGITS - 1);
                  state_d = ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            idx_d = idx_next;
            if (dcnt_q == 2'd0) begin
               t0_d    = '0;
               t1_d    = BIN_W'(1);
               n_d     = idx_next;
               state_d = ST_FIB;
            end else begin
               dcnt_d = dcnt_q - 2'd1;
            end
         end
         ST_FIB: begin
            // Stopping as soon as t0 leaves the range keeps t1 below 3*10**OUT_DIGITS.
            if (n_q == '0 || t0_big) begin
               dd_load = 1'b1;
               ovf_p_d = t0_big;
               state_d = ST_CONV;
            end else begin
               t0_d = t1_q;
               t1_d = t0_q + t1_q;
               n_d  = n_q - IDX_W'(1);
            end
         end
         ST_CONV: begin
            if (dd_done) state_d = ST_DONE;
         end
         ST_DONE: begin
            bcd_out_d = err_p_q ? '0 : dd_bcd;
            ovf_d     = ovf_p_q;
            err_d     = err_p_q;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      ready_d = (state_d == ST_IDLE);
      done_d  = (state_q == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         din_q     <= '0;
         idx_q     <= '0;
         n_q       <= '0;
         dcnt_q    <= '0;
         t0_q      <= '0;
         t1_q      <= '0;
         ovf_p_q   <= 1'b0;
         err_p_q   <= 1'b0;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
         bcd_out_q <= '0;
         ovf_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         din_q     <= din_d;
         idx_q     <= idx_d;
         n_q       <= n_d;
         dcnt_q    <= dcnt_d;
         t0_q      <= t0_d;
         t1_q      <= t1_d;
         ovf_p_q   <= ovf_p_d;
         err_p_q   <= err_p_d;
         ready_q   <= ready_d;
         done_q    <= done_d;
         bcd_out_q <= bcd_out_d;
         ovf_q     <= ovf_d;
         err_q     <= err_d;
      end
   end

   bin2bcd_dd #(
      .BIN_W      (BIN_W),
      .OUT_DIGITS (OUT_DIGITS)
   ) u_dd (
      .clk         (clk),
      .reset_n     (reset_n),
      .load_i      (dd_load),
      .bin_i       (dd_bin),
      .bcd_o       (dd_bcd),
      .done_tick_o (dd_done)
   );

   assign ready     = ready_q;
   assign done_tick = done_q;
   assign bcd_out   = bcd_out_q;
   assign ovf       = ovf_q;
   assign err       = err_q;

endmodule

// File: tb/tb_bcd_fib_param.sv
// Bench for bcd_fib_param (IN_DIGITS=2, OUT_DIGITS=4): transaction-level model checked
// every cycle, plus directed runs with literal results and latencies.
module tb_bcd_fib_param;

   localparam int MAXV  = 9999;
   localparam int BIN_W = 15;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  bcd_in = 8'h00;
   logic        ready, done_tick, ovf, err;
   logic [15:0] bcd_out;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   // model state
   bit          m_ready = 1'b1;
   bit          m_done = 1'b0;
   logic [15:0] m_bcd = '0;
   bit          m_ovf = 1'b0;
   bit          m_err = 1'b0;
   bit          m_pend = 1'b0;
   int          m_at = 0;
   logic [15:0] p_bcd;
   bit          p_ovf, p_err;

   bcd_fib_param #(.IN_DIGITS(2), .OUT_DIGITS(4)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .bcd_in    (bcd_in),
      .ready     (ready),
      .done_tick (done_tick),
      .bcd_out   (bcd_out),
      .ovf       (ovf),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // fib(n), or -1 once it exceeds MAXV
   function automatic int fib_sat(input int n);
      longint a, b, t;
      a = 0; b = 1;
      for (int i = 0; i < n; i++) begin
         t = a + b; a = b; b = t;
         if (a > MAXV) return -1;
      end
      return int'(a);
   endfunction

   function automatic int first_over();
      int k;
      k = 0;
      while (fib_sat(k) >= 0) k++;
      return k;
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int x;
      r = '0; x = v;
      for (int d = 0; d < 4; d++) begin
         r[4*d +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic int latency(input logic [7:0] v);
      int n, k, f;
      if (v[7:4] > 9 || v[3:0] > 9) return 1;
      n = int'(v[7:4]) * 10 + int'(v[3:0]);
      k = first_over();
      f = ((n < k) ? n : k) + 1;
      return 2 + f + BIN_W + 1;
   endfunction

   always @(posedge clk) begin
      cyc++;
      if (!reset_n) begin
         m_ready = 1'b1; m_done = 1'b0; m_bcd = '0; m_ovf = 1'b0; m_err = 1'b0; m_pend = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_ready && start) begin
            int f;
            p_err = (bcd_in[7:4] > 9) || (bcd_in[3:0] > 9);
            f = fib_sat(int'(bcd_in[7:4]) * 10 + int'(bcd_in[3:0]));
            p_ovf = !p_err && (f < 0);
            p_bcd = p_err ? 16'h0000 : (f < 0 ? to_bcd(MAXV) : to_bcd(f));
            m_at = cyc + latency(bcd_in);
            m_pend = 1'b1;
            m_ready = 1'b0;
         end else if (m_pend && cyc == m_at) begin
            m_done = 1'b1; m_bcd = p_bcd; m_ovf = p_ovf; m_err = p_err;
            m_ready = 1'b1; m_pend = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("ready", 32'(ready), 32'(m_ready));
         chk("done_tick", 32'(done_tick), 32'(m_done));
         chk("bcd_out", 32'(bcd_out), 32'(m_bcd));
         chk("ovf", 32'(ovf), 32'(m_ovf));
         chk("err", 32'(err), 32'(m_err));
      end
   end

   task automatic run(input logic [7:0] v, input logic [15:0] e_bcd, input bit e_ovf,
                      input bit e_err, input int e_lat);
      int s;
      bit seen;
      seen = 1'b0;
      @(negedge clk); #2;
      bcd_in = v; start = 1'b1;
      @(negedge clk); s = cyc; #2;
      start = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         if (done_tick) seen = 1'b1;
         else @(negedge clk);
      end
      if (!seen) begin
         total++; bad++;
         $display("FAIL timeout: no done_tick for bcd_in=%h", v);
      end else begin
         chk("latency", 32'(cyc - s), 32'(e_lat));
         chk("res_bcd", 32'(bcd_out), 32'(e_bcd));
         chk("res_ovf", 32'(ovf), 32'(e_ovf));
         chk("res_err", 32'(err), 32'(e_err));
      end
   endtask

   initial begin
      int dones, readies;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_bcd", 32'(bcd_out), 32'h0);
      #2 reset_n = 1'b1;

      chk("model_fib20", 32'(fib_sat(20)), 32'd6765);
      chk("model_k", 32'(first_over()), 32'd21);
      chk("model_lat20", 32'(latency(8'h20)), 32'd39);

      run(8'h20, 16'h6765, 1'b0, 1'b0, 39);
      run(8'h21, 16'h9999, 1'b1, 1'b0, 40);
      run(8'h99, 16'h9999, 1'b1, 1'b0, 40);
      run(8'h00, 16'h0000, 1'b0, 1'b0, 19);
      run(8'h01, 16'h0001, 1'b0, 1'b0, 20);
      run(8'h3A, 16'h0000, 1'b0, 1'b1, 1);
      run(8'h12, 16'h0144, 1'b0, 1'b0, 31);

      // reset while FIB of n=20 is running
      @(negedge clk); #2;
      bcd_in = 8'h20; start = 1'b1;
      @(negedge clk); #2;
      start = 1'b0;
      repeat (10) @(negedge clk);
      #2 reset_n = 1'b0;
      @(negedge clk); #2;
      reset_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (done_tick) dones++;
      end
      chk("abort_dones", 32'(dones), 32'd0);
      chk("abort_ready", 32'(ready), 32'd1);
      chk("abort_bcd", 32'(bcd_out), 32'h0);
      run(8'h10, 16'h0055, 1'b0, 1'b0, 29);

      // start held high: back-to-back runs, bcd_in wiggled mid-run
      @(negedge clk); #2;
      bcd_in = 8'h20; start = 1'b1;
      dones = 0; readies = 0;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         if (done_tick) dones++;
         if (ready) readies++;
         #2;
         bcd_in = ((i % 40) >= 5 && (i % 40) < 30) ? 8'h07 : 8'h20;
         if (i == 119) start = 1'b0;
      end
      chk("b2b_dones", 32'(dones), 32'd3);
      chk("b2b_ready", 32'(readies), 32'd3);
      chk("b2b_bcd", 32'(bcd_out), 32'h6765);
      repeat (5) @(negedge clk);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
